// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_alu                                                       |
// | Purpose  : Sequential ALU. Add, sub, logic, arithmetic shift and signed  |
// |            compare complete in one cycle. Signed multiply is a W-cycle   |
// |            shift-add on operand magnitudes when SEQ_ALU_MUL_EN is        |
// |            defined; otherwise opcode 110 returns zero in one cycle.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_alu #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          CTRL,
  input  logic signed [W-1:0] A,
  input  logic signed [W-1:0] B,
  output logic signed [W-1:0] R,
  output logic                O,
  output logic                N,
  output logic                Z,
  output logic                C,
  output logic                busy,
  output logic                done
);

  localparam int c_SHW = $clog2(W);

  logic [W-1:0] w_a_u;
  logic [W-1:0] w_b_u;
  logic [W:0]   w_sum;
  logic [W:0]   w_dif;

  assign w_a_u = A;
  assign w_b_u = B;
  // One extra bit on each side captures carry-out / borrow directly.
  assign w_sum = {1'b0, w_a_u} + {1'b0, w_b_u};
  assign w_dif = {1'b0, w_a_u} - {1'b0, w_b_u};

  logic [W-1:0] w_r;
  logic         w_o;
  logic         w_n;
  logic         w_c;

  // Single-cycle result and flags; opcode 110 yields zero here.
  always_comb begin
    w_r = '0;
    w_o = 1'b0;
    w_c = 1'b0;
    case (CTRL)
      3'b000: begin
        w_r = w_sum[W-1:0];
        w_c = w_sum[W];
        w_o = (A[W-1] == B[W-1]) && (w_sum[W-1] != A[W-1]);
      end
      3'b001: begin
        w_r = w_dif[W-1:0];
        w_c = w_dif[W];
        w_o = (A[W-1] != B[W-1]) && (w_dif[W-1] == B[W-1]);
      end
      3'b010:  w_r = w_a_u & w_b_u;
      3'b011:  w_r = w_a_u | w_b_u;
      3'b100:  w_r = w_a_u ^ w_b_u;
      3'b101:  w_r = A >>> B[c_SHW-1:0];
      3'b111:  w_r = {{(W-1){1'b0}}, (A < B)};
      default: w_r = '0;
    endcase
    // On overflow the result's MSB is wrong; A's sign is the true sign.
    w_n = w_o ? A[W-1] : w_r[W-1];
  end

`ifdef SEQ_ALU_MUL_EN
  localparam int               c_CW       = $clog2(W);
  localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
  localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(W - 1);
  localparam logic [W-1:0]     c_ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0]   c_ONE_2W   = {{(2*W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [c_CW-1:0]  r_cnt;
  logic [W-1:0]     r_mcand;
  logic [2*W-1:0]   r_p;
  logic             r_neg;

  logic [W-1:0]     w_mag_a;
  logic [W-1:0]     w_mag_b;
  logic [W:0]       w_acc;
  logic [2*W-1:0]   w_p_next;
  logic [2*W-1:0]   w_prod;
  logic             w_mo;
  logic             w_mn;

  // Magnitudes fit in W unsigned bits, including the most negative value.
  assign w_mag_a  = A[W-1] ? (~w_a_u + c_ONE_W) : w_a_u;
  assign w_mag_b  = B[W-1] ? (~w_b_u + c_ONE_W) : w_b_u;
  // Upper half accumulates the multiplicand when the current multiplier LSB
  // is set; the whole register then shifts right, keeping the carry.
  assign w_acc    = r_p[0] ? ({1'b0, r_p[2*W-1:W]} + {1'b0, r_mcand})
                           : {1'b0, r_p[2*W-1:W]};
  assign w_p_next = {w_acc, r_p[W-1:1]};
  assign w_prod   = r_neg ? (~w_p_next + c_ONE_2W) : w_p_next;
  // Fits in signed W bits only if the top W+1 bits are all equal.
  assign w_mo     = (|w_prod[2*W-1:W-1]) & ~(&w_prod[2*W-1:W-1]);
  // A zero product is non-negative whatever the operand signs.
  assign w_mn     = r_neg & (|w_p_next);

  // Control FSM with registered outputs: single-cycle ops finish in IDLE,
  // multiply iterates W times in MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_p     <= '0;
      r_neg   <= 1'b0;
      R       <= '0;
      O       <= 1'b0;
      N       <= 1'b0;
      Z       <= 1'b1;
      C       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (CTRL == 3'b110) begin
              r_state <= S_MUL;
              busy    <= 1'b1;
              r_cnt   <= '0;
              r_mcand <= w_mag_a;
              r_p     <= {{W{1'b0}}, w_mag_b};
              r_neg   <= A[W-1] ^ B[W-1];
            end else begin
              R    <= w_r;
              O    <= w_o;
              N    <= w_n;
              Z    <= ~|w_r;
              C    <= w_c;
              done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) begin
            R       <= w_prod[W-1:0];
            O       <= w_mo;
            N       <= w_mn;
            Z       <= ~|w_prod[W-1:0];
            C       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  // Every accepted request completes in one cycle; busy is never raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      R    <= '0;
      O    <= 1'b0;
      N    <= 1'b0;
      Z    <= 1'b1;
      C    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= 1'b0;
      if (start) begin
        R    <= w_r;
        O    <= w_o;
        N    <= w_n;
        Z    <= ~|w_r;
        C    <= w_c;
        done <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_alu                                                    |
// | Purpose  : Self-checking bench for seq_alu (W=16) with a transaction     |
// |            level reference model and directed literal checks.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_alu;

`ifdef SEQ_ALU_MUL_EN
  localparam bit c_MUL_BUILD = 1'b1;
`else
  localparam bit c_MUL_BUILD = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               start;
  logic [2:0]         CTRL;
  logic signed [15:0] A;
  logic signed [15:0] B;
  logic signed [15:0] R;
  logic               O, N, Z, C, busy, done;

  int n_asrt = 0;
  int n_fail = 0;

  seq_alu #(.W(16)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .CTRL  (CTRL),
    .A     (A),
    .B     (B),
    .R     (R),
    .O     (O),
    .N     (N),
    .Z     (Z),
    .C     (C),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of one operation from plain signed/unsigned arithmetic:
  // packed as {R, O, N, Z, C}.
  function automatic logic [19:0] model_op(input logic [2:0] c,
                                           input logic signed [15:0] a,
                                           input logic signed [15:0] b);
    longint     sa, sb, ua, ub, res;
    logic [15:0] r;
    logic       o, n, cy;
    sa = longint'(a);
    sb = longint'(b);
    ua = longint'($unsigned(a));
    ub = longint'($unsigned(b));
    res = 0; o = 1'b0; cy = 1'b0;
    case (c)
      3'd0: begin res = sa + sb; o = (res > 32767) || (res < -32768); cy = (ua + ub) > 65535; end
      3'd1: begin res = sa - sb; o = (res > 32767) || (res < -32768); cy = (ua < ub); end
      3'd2: res = sa & sb;
      3'd3: res = sa | sb;
      3'd4: res = sa ^ sb;
      3'd5: res = sa >>> b[3:0];
      3'd6: begin
        if (c_MUL_BUILD) begin
          res = sa * sb;
          o   = (res > 32767) || (res < -32768);
        end
      end
      default: res = (sa < sb) ? 1 : 0;
    endcase
    r = res[15:0];
    n = (c == 3'd0 || c == 3'd1 || c == 3'd6) ? (res < 0) : r[15];
    return {r, o, n, (r == 16'h0000), cy};
  endfunction

  // Reference model state.
  logic [15:0] m_R;
  logic        m_O, m_N, m_Z, m_C, m_busy, m_done;
  logic [19:0] m_pend;
  int          m_left;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_R = '0; m_O = 0; m_N = 0; m_Z = 1; m_C = 0;
      m_busy = 0; m_done = 0; m_left = 0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          {m_R, m_O, m_N, m_Z, m_C} = m_pend;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (c_MUL_BUILD && CTRL == 3'b110) begin
          m_pend = model_op(CTRL, A, B);
          m_busy = 1'b1;
          m_left = 16;
        end else begin
          {m_R, m_O, m_N, m_Z, m_C} = model_op(CTRL, A, B);
          m_done = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {10'd0, R, O, N, Z, C, busy, done};
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid)
      chk("model", dut_vec(), {10'd0, m_R, m_O, m_N, m_Z, m_C, m_busy, m_done});
  end

  task automatic lit(input string nm, input logic [15:0] r, input logic o, n, z, c, bz, dn);
    chk(nm, dut_vec(), {10'd0, r, o, n, z, c, bz, dn});
  endtask

  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    start = 1'b1; CTRL = c; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic single(input string nm, input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] r,
                        input logic o, n, z, cy);
    issue(c, a, b);
    @(negedge clk);
    lit(nm, r, o, n, z, cy, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit saw_busy = 1'b0;
  always @(negedge clk) if (busy === 1'b1) saw_busy = 1'b1;

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; CTRL = 3'b000; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("reset", 16'h0000, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    single("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 0);
    @(negedge clk);
    lit("add_hold", 16'h8000, 1, 0, 0, 0, 0, 0);
    single("sub_borrow", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 0, 1, 0, 1);
    single("sub_ovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0);
    single("add_carry", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 0, 0, 1, 1);
    single("and", 3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0);
    single("or", 3'b011, 16'h8000, 16'h0001, 16'h8001, 0, 1, 0, 0);
    single("xor_zero", 3'b100, 16'h5555, 16'h5555, 16'h0000, 0, 0, 1, 0);
    single("asr15", 3'b101, 16'h8000, 16'h000F, 16'hFFFF, 0, 1, 0, 0);
    single("asr_lowbits", 3'b101, 16'hF000, 16'h0013, 16'hFE00, 0, 1, 0, 0);
    single("slt_true", 3'b111, 16'hFFFF, 16'h0000, 16'h0001, 0, 0, 0, 0);
    single("slt_false", 3'b111, 16'h0005, 16'h0003, 16'h0000, 0, 0, 1, 0);
    single("slt_extreme", 3'b111, 16'h8000, 16'h7FFF, 16'h0001, 0, 0, 0, 0);

`ifdef SEQ_ALU_MUL_EN
    // -3 * 5 with an ignored add request in the middle of the operation.
    issue(3'b110, 16'hFFFD, 16'h0005);
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < 40) begin
      k++;
      if (k == 5) begin start = 1'b1; CTRL = 3'b000; A = 16'h0001; B = 16'h0001; end
      if (k == 6) start = 1'b0;
      @(negedge clk);
    end
    chk("mul_busy_cycles", 32'(k), 32'd16);
    lit("mul_neg", 16'hFFF1, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    lit("mul_done_once", 16'hFFF1, 0, 1, 0, 0, 0, 0);

    issue(3'b110, 16'h0100, 16'h0100);
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("mul_ovf_cycles", 32'(k), 32'd16);
    lit("mul_ovf", 16'h0000, 1, 0, 1, 0, 0, 1);

    // Abort a multiply with reset at its seventh cycle.
    issue(3'b110, 16'h0007, 16'h0009);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
`else
    single("mul_absent", 3'b110, 16'h0002, 16'h0003, 16'h0000, 0, 0, 1, 0);
    @(posedge clk); #1;
    rst = 1'b1;
`endif
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1; CTRL = 3'b000; A = 16'h0002; B = 16'h0003;
    @(negedge clk);
    lit("rst_values", 16'h0000, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    lit("add_after_rst", 16'h0005, 0, 0, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    if (!c_MUL_BUILD) chk("busy_never", 32'(saw_busy), 32'd0);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The module SHALL have parameter W, default 16, giving the operand and result width in bits; legal values are 4 to 64.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: operation request, sampled only while busy=0.
REQ-005 The module SHALL have port CTRL, input, 3 bits: opcode, sampled with start.
REQ-006 The module SHALL have ports A and B, each input, signed, W bits: operands, sampled with start.
REQ-007 The module SHALL have port R, output reg, signed, W bits: result.
REQ-008 The module SHALL have ports O, N, Z and C, each output reg, 1 bit: overflow, true sign, zero and carry/borrow flags.
REQ-009 The module SHALL have port busy, output reg, 1 bit: multi-cycle operation in progress.
REQ-010 The module SHALL have port done, output reg, 1 bit: one-cycle pulse marking new R and flags.

Function
REQ-011 The opcodes SHALL be: 000 add; 001 sub (A-B); 010 AND; 011 OR; 100 XOR; 101 arithmetic shift right of A by B[clog2(W)-1:0]; 110 signed multiply; 111 signed less-than (R=1 if A<B, else 0).
REQ-012 The FSM SHALL have states IDLE and MUL; reset enters IDLE.
REQ-013 In IDLE with start=1 and a single-cycle opcode, R and all flags SHALL update at that same edge, and done SHALL be 1 for the following cycle only; latency is 1 cycle.
REQ-014 In IDLE with start=1 and CTRL=110, the FSM SHALL enter MUL and set busy=1; a shift-add on operand magnitudes runs for exactly W cycles.
REQ-015 At the W-th edge in MUL, R and flags SHALL update, busy SHALL fall, done SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-016 start SHALL be ignored while busy=1; no queuing.
REQ-017 R and the flags SHALL hold their last values between completions.
REQ-018 For add and sub, O SHALL be 1 on signed overflow: add when A and B share a sign and R differs from it; sub when A and B differ in sign and R's sign equals B's sign.
REQ-019 For add and sub, N SHALL equal R[W-1] when O=0 and A[W-1] when O=1.
REQ-020 C SHALL be the unsigned carry-out for add and the unsigned borrow (A<B unsigned) for sub; C SHALL be 0 for all other opcodes.
REQ-021 For multiply, R SHALL be the low W bits of the 2W-bit signed product; O SHALL be 1 when the product does not fit in signed W bits; N SHALL be the sign of the true product.
REQ-022 For logic, shift and compare opcodes, O SHALL be 0 and N SHALL equal R[W-1].
REQ-023 For every opcode, Z SHALL equal (R==0).

Reset
REQ-024 While rst=1 at an edge: R=0, O=0, N=0, C=0, Z=1, busy=0, done=0, and the FSM SHALL be in IDLE.
REQ-025 rst SHALL take priority over start and over an in-progress multiply; the multiply SHALL be aborted with no done pulse.
REQ-026 A start in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro SEQ_ALU_MUL_EN SHALL control the multiply feature.
REQ-028 With SEQ_ALU_MUL_EN defined, opcode 110 SHALL behave per REQ-014 and REQ-015.
REQ-029 Without SEQ_ALU_MUL_EN, the MUL state and its datapath SHALL be absent; opcode 110 SHALL complete in 1 cycle with R=0, O=0, N=0, C=0, Z=1, and busy SHALL remain 0.

Verification (W=16)
REQ-030 The bench SHALL cover add: A=0x7FFF, B=0x0001 -> R=0x8000, O=1, N=0, C=0, Z=0, done one cycle after start.
REQ-031 The bench SHALL cover sub: A=0x0000, B=0x0001 -> R=0xFFFF, O=0, N=1, C=1; and A=0x8000, B=0x0001 -> R=0x7FFF, O=1, N=1, C=0.
REQ-032 The bench SHALL cover multiply: A=-3, B=5 -> busy for 16 cycles, then R=0xFFF1, N=1, O=0, a single done pulse; a start with CTRL=000 issued mid-operation SHALL be ignored.
REQ-033 The bench SHALL cover multiply overflow: A=0x0100, B=0x0100 -> R=0x0000, O=1, N=0, Z=1.
REQ-034 The bench SHALL cover reset mid-operation: rst at MUL cycle 7 -> all outputs at reset values, no done pulse; an add of 2+3 next cycle -> R=5.
REQ-035 The bench SHALL cover the build without SEQ_ALU_MUL_EN: CTRL=110, A=2, B=3 -> done after 1 cycle, R=0, Z=1, busy never 1.
